// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer controller.
// Holds the FSM state encoding, chip-select count and default CS timing.
package spi_ctrl_pkg;

  localparam int NUM_CS       = 4;
  localparam int CS_SETUP_DEF = 4;
  localparam int CS_HOLD_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CS_HOLD
  } state_t;

  // Active-low one-hot chip select for a given index.
  function automatic logic [NUM_CS-1:0] cs_decode_n(input logic [1:0] sel);
    cs_decode_n = ~(NUM_CS'(1) << sel);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Byte-level link between the transfer controller and an SPI byte master.
// The controller drives the master modport; a byte master (or a model of one) uses slave.
interface spi_xfer_ctrl_if;

  logic [1:0]                        mode;
  logic                              tx_data_valid;
  logic [7:0]                        tx_data;
  logic                              tx_ready;
  logic [7:0]                        rx_data;
  logic [spi_ctrl_pkg::NUM_CS-1:0]   cs_n;

  modport master (
    output mode, tx_data_valid, tx_data, cs_n,
    input  tx_ready, rx_data
  );

  modport slave (
    input  mode, tx_data_valid, tx_data, cs_n,
    output tx_ready, rx_data
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the index after the last winner.
// The pointer only moves on the advance strobe, so a grant is held stable until then.
module spi_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;

  // Walk from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    grant_o = '0;
    w_idx   = r_last;
    w_cand  = r_last;
    for (int off = N; off >= 1; off--) begin
      w_cand = IDX_W'((int'(r_last) + off) % N);
      if (req_i[w_cand]) begin
        grant_o         = '0;
        grant_o[w_cand] = 1'b1;
        w_idx           = w_cand;
      end
    end
  end

  // Pointer resets to the top index so index 0 is searched first.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_last <= IDX_W'(N - 1);
    end else if (advance_i && |req_i) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-requester SPI transaction controller: arbitrates, frames chip select and
// sequences bytes through a shared SPI byte master.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CS_SETUP_CYC = CS_SETUP_DEF,
  parameter int CS_HOLD_CYC  = CS_HOLD_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*4-1:0] len_i,
  input  logic [NUM_REQ*2-1:0] cs_sel_i,
  input  logic [NUM_REQ*8-1:0] wdata_i,
  output logic [NUM_REQ-1:0]   wdata_pop_o,
  output logic [7:0]           rdata_o,
  output logic [NUM_REQ-1:0]   rdata_valid_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  input  logic [7:0]           mode_cfg_i,
  output logic [1:0]           mode_o,
  output logic                 tx_data_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  input  logic [7:0]           rx_data_i,
  output logic [NUM_CS-1:0]    cs_n_o
);

  localparam int CYC_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(CS_SETUP_CYC - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(CS_HOLD_CYC - 1);

  state_t               r_state, w_next;
  logic [CYC_W-1:0]     r_cyc;
  logic [3:0]           r_bytes;
  logic [1:0]           r_cs, r_mode;
  logic [7:0]           r_rdata;
  logic [NUM_REQ-1:0]   r_grant, r_rdata_valid, r_done;

  logic [NUM_REQ-1:0]   w_arb_grant;
  logic                 w_advance, w_fire, w_byte_done;
  logic [3:0]           w_len;
  logic [1:0]           w_cs;
  logic [7:0]           w_wdata;

  spi_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .advance_i (w_advance),
    .grant_o   (w_arb_grant)
  );

  // Grants are one-hot, so a plain overwrite selects the winner's fields.
  always_comb begin
    w_len   = '0;
    w_cs    = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_len = len_i[i*4 +: 4];
        w_cs  = cs_sel_i[i*2 +: 2];
      end
      if (r_grant[i]) w_wdata = wdata_i[i*8 +: 8];
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    w_fire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_i) begin
          w_advance = 1'b1;
          w_next    = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP:  if (r_cyc == SETUP_LAST) w_next = ST_LOAD;
      ST_LOAD: begin
        if (tx_ready_i) begin
          w_fire = 1'b1;
          w_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: if (!tx_ready_i) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready_i) w_next = (r_bytes == 4'd0) ? ST_CS_HOLD : ST_LOAD;
      ST_CS_HOLD:   if (r_cyc == HOLD_LAST) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  assign w_byte_done = (r_state == ST_WAIT_DONE) && tx_ready_i;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state       <= ST_IDLE;
      r_cyc         <= '0;
      r_bytes       <= '0;
      r_cs          <= '0;
      r_mode        <= '0;
      r_rdata       <= '0;
      r_grant       <= '0;
      r_rdata_valid <= '0;
      r_done        <= '0;
    end else begin
      r_state       <= w_next;
      r_cyc         <= (w_next != r_state) ? '0 : r_cyc + CYC_W'(1);
      r_rdata_valid <= '0;
      r_done        <= '0;
      if (w_advance) begin
        r_grant <= w_arb_grant;
        r_bytes <= w_len;
        r_cs    <= w_cs;
        r_mode  <= mode_cfg_i[{w_cs, 1'b0} +: 2];
      end
      if (w_byte_done) begin
        r_rdata       <= rx_data_i;
        r_rdata_valid <= r_grant;
        // Saturate at zero so a 16-byte transfer never wraps the counter.
        if (r_bytes != 4'd0) r_bytes <= r_bytes - 4'd1;
      end
      if (r_state == ST_CS_HOLD && w_next == ST_IDLE) begin
        r_done  <= r_grant;
        r_grant <= '0;
      end
    end
  end

  // CS decodes straight from the state register so an async reset releases it at once.
  assign cs_n_o          = (r_state == ST_IDLE) ? '1 : cs_decode_n(r_cs);
  assign tx_data_valid_o = w_fire;
  assign tx_data_o       = (r_state == ST_LOAD) ? w_wdata : 8'h00;
  assign wdata_pop_o     = r_grant & {NUM_REQ{w_fire}};
  assign grant_o         = r_grant;
  assign done_o          = r_done;
  assign rdata_valid_o   = r_rdata_valid;
  assign rdata_o         = r_rdata;
  assign mode_o          = r_mode;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: loopback byte-master model, scoreboard of
// expected received bytes and done pulses, popped by an independent monitor.
module tb_spi_xfer_ctrl;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [NR-1:0]   req, pop, rvalid, grant, done;
  logic [NR*4-1:0] len;
  logic [NR*2-1:0] cs_sel;
  logic [NR*8-1:0] wdata;
  logic [7:0]      rdata, mode_cfg;

  spi_xfer_ctrl_if bm ();

  spi_xfer_ctrl #(.NUM_REQ(NR), .CS_SETUP_CYC(4), .CS_HOLD_CYC(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_i           (req),
    .len_i           (len),
    .cs_sel_i        (cs_sel),
    .wdata_i         (wdata),
    .wdata_pop_o     (pop),
    .rdata_o         (rdata),
    .rdata_valid_o   (rvalid),
    .grant_o         (grant),
    .done_o          (done),
    .mode_cfg_i      (mode_cfg),
    .mode_o          (bm.mode),
    .tx_data_valid_o (bm.tx_data_valid),
    .tx_data_o       (bm.tx_data),
    .tx_ready_i      (bm.tx_ready),
    .rx_data_i       (bm.rx_data),
    .cs_n_o          (bm.cs_n)
  );

  typedef struct { int r; logic [7:0] d; } exp_t;
  exp_t sb_q[$];
  int   done_q[$];
  exp_t mon_e;
  int   mon_d;

  int n_checks = 0, n_fail = 0;
  int tx_count = 0, rv_count = 0, done_count = 0, exp_done = 0;

  logic [7:0] tx_mem [NR][16];
  logic [3:0] ptr [NR];
  logic [NR-1:0] pops_seen;
  logic [7:0] bm_byte;

  localparam logic [7:0] LONG_BYTES [16] = '{
    8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
    8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'hEF, 8'hF0
  };

  always_comb begin
    wdata = '0;
    for (int r = 0; r < NR; r++) wdata[r*8 +: 8] = tx_mem[r][ptr[r]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester data source: advance to the next byte after each pop.
  initial begin
    forever begin
      @(negedge clk);
      pops_seen = pop;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) if (pops_seen[r]) ptr[r] = ptr[r] + 4'd1;
    end
  end

  // Byte master model: busy for a few cycles, then returns the sent byte (loopback).
  initial begin
    bm.tx_ready = 1'b1;
    bm.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bm.tx_data_valid) begin
        bm_byte = bm.tx_data;
        tx_count++;
        @(posedge clk);
        #1 bm.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bm.rx_data  = bm_byte;
        bm.tx_ready = 1'b1;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pops on each output pulse.
  always @(negedge clk) begin
    check("cs_at_most_one_low", 32'($countones(~bm.cs_n) <= 1), 32'd1);
    if (bm.tx_data_valid) check("tx_valid_inside_txn", 32'(bm.cs_n != 4'hF), 32'd1);
    if (|rvalid) begin
      rv_count++;
      if (sb_q.size() == 0) check("rdata_unexpected", 32'(rvalid), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        check("rdata_owner", 32'(rvalid), 32'(1 << mon_e.r));
        check("rdata_o", 32'(rdata), 32'(mon_e.d));
      end
    end
    if (|done) begin
      done_count++;
      if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else begin
        mon_d = done_q.pop_front();
        check("done_owner", 32'(done), 32'(1 << mon_d));
      end
    end
  end

  task automatic set_fields(input int r, input logic [3:0] l, input logic [1:0] cs);
    len[r*4 +: 4]    = l;
    cs_sel[r*2 +: 2] = cs;
    ptr[r]           = 4'd0;
  endtask

  task automatic load(input int r, input int i, input logic [7:0] b);
    tx_mem[r][i] = b;
    sb_q.push_back('{r: r, d: b});
  endtask

  task automatic wait_grant(input int r, input string name);
    for (int c = 0; c < 400 && !grant[r]; c++) @(negedge clk);
    check(name, 32'(grant), 32'(1 << r));
  endtask

  task automatic wait_done();
    for (int c = 0; c < 3000 && done_count < exp_done; c++) @(negedge clk);
    check("done_count", 32'(done_count), 32'(exp_done));
  endtask

  task automatic do_pair(input int first, input int second,
                         input logic [7:0] bf, input logic [7:0] bs);
    set_fields(first, 4'd0, 2'(first));
    set_fields(second, 4'd0, 2'(second));
    load(first, 0, bf);
    load(second, 0, bs);
    done_q.push_back(first);
    done_q.push_back(second);
    exp_done += 2;
    req = '1;
    wait_grant(first, "rr_first_grant");
    req[first] = 1'b0;
    wait_grant(second, "rr_second_grant");
    req[second] = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    reset_i  = 1'b0;
    req      = '0;
    len      = '0;
    cs_sel   = '0;
    mode_cfg = 8'h00;
    for (int r = 0; r < NR; r++) begin
      ptr[r] = 4'd0;
      for (int i = 0; i < 16; i++) tx_mem[r][i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("reset_cs_n", 32'(bm.cs_n), 32'hF);
    check("reset_mode", 32'(bm.mode), 32'd0);
    check("reset_tx_data", 32'(bm.tx_data), 32'd0);
    check("reset_tx_valid", 32'(bm.tx_data_valid), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_pop", 32'(pop), 32'd0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);

    // Both together straight after reset: 0 wins, then 1.
    do_pair(0, 1, 8'h11, 8'h22);

    // Three-byte transfer on CS1 from requester 0.
    set_fields(0, 4'd2, 2'd1);
    load(0, 0, 8'hA5);
    load(0, 1, 8'h3C);
    load(0, 2, 8'hFF);
    done_q.push_back(0);
    exp_done++;
    req[0] = 1'b1;
    wait_grant(0, "three_byte_grant");
    req[0] = 1'b0;
    check("three_byte_cs_n", 32'(bm.cs_n), 32'hD);
    wait_done();
    check("three_byte_rvalid_count", 32'(rv_count), 32'd5);

    // Last winner was 0, so a simultaneous pair now goes 1 then 0.
    do_pair(1, 0, 8'h33, 8'h44);

    // Mode comes from mode_cfg_i[7:6] for CS3 and is frozen for the transfer.
    mode_cfg = 8'hC0;
    set_fields(1, 4'd1, 2'd3);
    load(1, 0, 8'h12);
    load(1, 1, 8'h34);
    done_q.push_back(1);
    exp_done++;
    req[1] = 1'b1;
    for (int c = 0; c < 400 && bm.cs_n[3]; c++) @(negedge clk);
    req[1] = 1'b0;
    check("mode_at_cs3_low", 32'(bm.mode), 32'd3);
    check("cs3_low", 32'(bm.cs_n), 32'h7);
    mode_cfg = 8'h00;
    len[1*4 +: 4] = 4'hF;
    repeat (8) @(negedge clk);
    check("mode_frozen", 32'(bm.mode), 32'd3);
    check("cs3_still_low", 32'(bm.cs_n), 32'h7);
    wait_done();

    // Sixteen bytes, then CS released after exactly four hold cycles.
    set_fields(0, 4'hF, 2'd0);
    for (int i = 0; i < 16; i++) load(0, i, LONG_BYTES[i]);
    done_q.push_back(0);
    exp_done++;
    tx_count = 0;
    req[0] = 1'b1;
    wait_grant(0, "long_grant");
    req[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 3000 && n < 16; c++) begin
      @(negedge clk);
      if (rvalid[0]) n++;
    end
    check("long_rvalid_count", 32'(n), 32'd16);
    cyc = 0;
    for (int c = 0; c < 50 && (cyc == 0 || bm.cs_n != 4'hF); c++) begin
      @(negedge clk);
      cyc++;
    end
    check("long_hold_cycles", 32'(cyc), 32'd4);
    wait_done();
    check("long_tx_count", 32'(tx_count), 32'd16);

    // Reset during the fifth byte: CS drops at once and no done follows.
    set_fields(0, 4'd7, 2'd2);
    for (int i = 0; i < 8; i++) load(0, i, 8'(8'h81 + i));
    tx_count = 0;
    req[0] = 1'b1;
    wait_grant(0, "abort_grant");
    req[0] = 1'b0;
    for (int c = 0; c < 1000 && tx_count < 5; c++) @(negedge clk);
    check("abort_reached_byte5", 32'(tx_count), 32'd5);
    @(posedge clk);
    #2 reset_i = 1'b0;
    #1;
    check("abort_cs_released", 32'(bm.cs_n), 32'hF);
    check("abort_grant_cleared", 32'(grant), 32'd0);
    check("abort_bytes_received", 32'(sb_q.size()), 32'd4);
    sb_q.delete();
    repeat (4) @(negedge clk);
    reset_i = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(exp_done));

    set_fields(0, 4'd0, 2'd0);
    load(0, 0, 8'h5A);
    done_q.push_back(0);
    exp_done++;
    req[0] = 1'b1;
    wait_grant(0, "post_reset_grant");
    req[0] = 1'b0;
    check("post_reset_mode", 32'(bm.mode), 32'd0);
    wait_done();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
